// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Runs the physical register accesses on the RTC chip's multiplexed
// address/data bus. A start strobe latches the Control mode and the
// sequencer then plays that mode's fixed burst of accesses. Each access is
// an address phase, a one-cycle gap, a data phase and a trailing gap.
//
// Ports
//   reloj, resetM        clock (rising edge), async active-low reset
//   Control, start       mode select (00=I 01=L 10=E 11=M_S), burst strobe
//   wr_data / wr_idx     write byte supplied for the register at wr_idx
//   rd_data/rd_idx/rd_valid  captured read byte, its index, 1-cycle strobe
//   busy, done           burst in progress, 1-cycle end-of-burst strobe
//   CS_n RD_n WR_n AD_n  RTC pin strobes (AD_n: 0 = address, 1 = data)
//   ad_out, ad_oe, ad_in bus drive value, drive enable, bus sample
//
// Build option
//   RTC_XFER_CMD_EN  when defined, an L burst is preceded by a 0xF0 command
//                    write and an E burst is followed by a 0xF1 command write.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | address phase, T_PH cycles
// GAP1  | one cycle between address and data phase
// DATA  | data phase, T_PH cycles
// GAP2  | T_GAP idle cycles, then next access or DONE
// DONE  | one-cycle done strobe
module rtc_bus_sequencer #(
  parameter int T_PH  = 8,
  parameter int T_GAP = 2,
  parameter int N_REG = 9
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [1:0] Control,
  input  logic       start,
  input  logic [7:0] wr_data,
  output logic [3:0] wr_idx,
  output logic [7:0] rd_data,
  output logic [3:0] rd_idx,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

`ifdef RTC_XFER_CMD_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif

  localparam logic [4:0] PH_LD    = 5'(T_PH - 1);
  localparam logic [4:0] GAP_LD   = 5'(T_GAP - 1);
  localparam logic [3:0] LAST_REG = 4'(N_REG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_I = 2'b00, M_L = 2'b01, M_E = 2'b10, M_S = 2'b11
  } mode_t;

  state_t     state, state_nxt;
  mode_t      mode;
  logic [4:0] cnt, cnt_load;
  logic [3:0] idx;
  logic       cmd;        // current access is the transfer command
  logic [7:0] wdata_q;
  logic       last_acc, acc_wr;
  logic [7:0] acc_addr, acc_wdata;

  function automatic logic [7:0] reg_addr(input logic [3:0] i);
    case (i)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h41;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h43;
      default: reg_addr = 8'h00;
    endcase
  endfunction

  // What the current access looks like
  always_comb begin
    last_acc  = (mode == M_I) ? (idx == 4'd1) : (idx == LAST_REG);
    acc_wr    = cmd || (mode != M_L);
    acc_addr  = reg_addr(idx);
    acc_wdata = wr_data;
    if (cmd) begin
      acc_addr  = (mode == M_L) ? 8'hF0 : 8'hF1;
      acc_wdata = acc_addr;
    end else if (mode == M_I) begin
      acc_addr  = 8'h02;
      acc_wdata = (idx == 4'd0) ? 8'h10 : 8'h00;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (mode_t'(Control) == M_S) ? S_DONE : S_ADDR;
      S_ADDR: if (cnt == 5'd0) state_nxt = S_GAP1;
      S_GAP1: state_nxt = S_DATA;
      S_DATA: if (cnt == 5'd0) state_nxt = S_GAP2;
      S_GAP2: begin
        if (cnt == 5'd0) begin
          if (cmd)                              // prefix leads into reg 0, suffix ends burst
            state_nxt = (mode == M_E) ? S_DONE : S_ADDR;
          else if (!last_acc)
            state_nxt = S_ADDR;
          else if (CMD_EN && mode == M_E)
            state_nxt = S_ADDR;
          else
            state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_ADDR, S_DATA: cnt_load = PH_LD;
      S_GAP2:         cnt_load = GAP_LD;
      default:        cnt_load = 5'd0;
    endcase
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= cnt_load;
      else if (cnt != 5'd0)   cnt <= cnt - 5'd1;
    end
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      mode <= M_I;
      idx  <= 4'd0;
      cmd  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      mode <= mode_t'(Control);
      idx  <= 4'd0;
      cmd  <= CMD_EN && (mode_t'(Control) == M_L);
    end else if (state == S_GAP2 && cnt == 5'd0) begin
      if (cmd)
        cmd <= 1'b0;
      else if (!last_acc)
        idx <= idx + 4'd1;
      else if (CMD_EN && mode == M_E)
        cmd <= 1'b1;
    end
  end

  // Write byte is frozen on the first address cycle so the data phase
  // drives a stable value even if wr_data moves afterwards.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      wdata_q  <= 8'h00;
      rd_data  <= 8'h00;
      rd_idx   <= 4'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == S_ADDR && cnt == PH_LD)
        wdata_q <= acc_wdata;
      if (state == S_DATA && cnt == 5'd0 && !acc_wr) begin
        rd_data  <= ad_in;
        rd_idx   <= idx;
        rd_valid <= 1'b1;
      end
    end
  end

  assign wr_idx = idx;

  always_comb begin
    CS_n   = 1'b1;
    RD_n   = 1'b1;
    WR_n   = 1'b1;
    AD_n   = 1'b1;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    case (state)
      S_ADDR: begin
        CS_n   = 1'b0;
        WR_n   = 1'b0;
        AD_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = acc_addr;
      end
      S_GAP1: begin
        ad_oe  = 1'b1;
        ad_out = acc_addr;
      end
      S_DATA: begin
        CS_n = 1'b0;
        if (acc_wr) begin
          WR_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end else begin
          RD_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;

`ifdef RTC_XFER_CMD_EN
  localparam int CMD = 1;
`else
  localparam int CMD = 0;
`endif

  logic       reloj = 1'b0;
  logic       resetM;
  logic [1:0] Control;
  logic       start;
  logic [7:0] wr_data;
  logic [3:0] wr_idx;
  logic [7:0] rd_data;
  logic [3:0] rd_idx;
  logic       rd_valid, busy, done;
  logic       CS_n, RD_n, WR_n, AD_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  rtc_bus_sequencer dut (
    .reloj(reloj), .resetM(resetM), .Control(Control), .start(start),
    .wr_data(wr_data), .wr_idx(wr_idx), .rd_data(rd_data), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .busy(busy), .done(done), .CS_n(CS_n), .RD_n(RD_n),
    .WR_n(WR_n), .AD_n(AD_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 reloj = ~reloj;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                               8'h41, 8'h42, 8'h43};

  logic [7:0] addr_q[$];
  logic [7:0] wdat_q[$];
  logic [7:0] rdd_q[$];
  logic [3:0] rdi_q[$];
  int done_c, busy_lo_c, done_pulses;
  int ovl_cnt, cs_bad_cnt, wr_bad_cnt, rdlow_cnt, cslow_cnt;
  logic rd_n_at_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a burst and observes the pins cycle by cycle; cycle 1 is the
  // cycle right after the start edge. inj_c re-strobes start with the
  // opposite Control; rst_c pulls resetM low at that cycle and returns.
  task automatic run_burst(input logic [1:0] ctl, input int inj_c,
                           input int rst_c, input int max_c);
    logic prev_a, prev_w, prev_r;
    int rph;
    addr_q.delete(); wdat_q.delete(); rdd_q.delete(); rdi_q.delete();
    done_c = -1; busy_lo_c = -1; done_pulses = 0;
    ovl_cnt = 0; cs_bad_cnt = 0; wr_bad_cnt = 0; rdlow_cnt = 0; cslow_cnt = 0;
    prev_a = 1'b0; prev_w = 1'b0; prev_r = 1'b0; rph = 0;
    rd_n_at_rst = 1'b1;
    @(negedge reloj);
    Control = ctl;
    start   = 1'b1;
    @(posedge reloj);
    #1 start = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge reloj);
      if (!CS_n && !AD_n && !prev_a) addr_q.push_back(ad_out);
      if (!CS_n && AD_n && !WR_n && !prev_w) wdat_q.push_back(ad_out);
      if (!RD_n && !prev_r) begin
        ad_in = 8'h30 + 8'(rph);
        rph++;
      end
      prev_a = !CS_n && !AD_n;
      prev_w = !CS_n && AD_n && !WR_n;
      prev_r = !RD_n;
      wr_data = 8'h50 + {4'h0, wr_idx};
      if (!RD_n && !WR_n) ovl_cnt++;
      if (!CS_n && RD_n && WR_n) cs_bad_cnt++;
      if (!WR_n && CS_n) wr_bad_cnt++;
      if (!RD_n) rdlow_cnt++;
      if (!CS_n) cslow_cnt++;
      if (rd_valid) begin
        rdd_q.push_back(rd_data);
        rdi_q.push_back(rd_idx);
      end
      if (done) begin
        done_pulses++;
        if (done_c < 0) done_c = c;
      end
      if (!busy) begin
        busy_lo_c = c;
        break;
      end
      start = (c == inj_c);
      if (c == inj_c) Control = ~ctl;
      if (c == rst_c) begin
        rd_n_at_rst = RD_n;
        resetM = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int rv;
    resetM = 1'b0; Control = 2'b00; start = 1'b0; wr_data = 8'h00; ad_in = 8'h00;
    #1;
    chk("rst CS_n", CS_n, 1);
    chk("rst RD_n", RD_n, 1);
    chk("rst WR_n", WR_n, 1);
    chk("rst AD_n", AD_n, 1);
    chk("rst ad_oe", ad_oe, 0);
    chk("rst ad_out", ad_out, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst wr_idx", wr_idx, 0);
    repeat (3) @(negedge reloj);
    resetM = 1'b1;

    // 1: L burst
    run_burst(2'b01, -1, -1, 400);
    chk("L rd count", rdi_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("L rd_idx %0d", i), rdi_q[i], i);
      chk($sformatf("L rd_data %0d", i), rdd_q[i], 8'h30 + i);
      chk($sformatf("L addr %0d", i), addr_q[i + CMD], addr_tbl[i]);
    end
    chk("L addr count", addr_q.size(), 9 + CMD);
    chk("L done cycle", done_c, 172 + 19 * CMD);
    chk("L busy low cycle", busy_lo_c, 173 + 19 * CMD);
    chk("L done pulses", done_pulses, 1);
    chk("L rd/wr overlap", ovl_cnt, 0);
    chk("L CS_n idle low", cs_bad_cnt, 0);
    chk("L wdata count", wdat_q.size(), CMD);
    if (CMD == 1) begin
      chk("L cmd addr", addr_q[0], 8'hF0);
      chk("L cmd data", wdat_q[0], 8'hF0);
    end

    // 2: E burst
    run_burst(2'b10, -1, -1, 400);
    chk("E wdata count", wdat_q.size(), 9 + CMD);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("E wdata %0d", i), wdat_q[i], 8'h50 + i);
      chk($sformatf("E addr %0d", i), addr_q[i], addr_tbl[i]);
    end
    chk("E RD_n low cycles", rdlow_cnt, 0);
    chk("E rd_valid count", rdi_q.size(), 0);
    chk("E WR_n low outside access", wr_bad_cnt, 0);
    chk("E CS_n idle low", cs_bad_cnt, 0);
    chk("E done cycle", done_c, 172 + 19 * CMD);
    chk("E wr_idx after", wr_idx, 8);
    if (CMD == 1) begin
      chk("E cmd addr", addr_q[9], 8'hF1);
      chk("E cmd data", wdat_q[9], 8'hF1);
    end

    // 3: I burst
    run_burst(2'b00, -1, -1, 100);
    chk("I addr count", addr_q.size(), 2);
    chk("I addr 0", addr_q[0], 8'h02);
    chk("I addr 1", addr_q[1], 8'h02);
    chk("I data 0", wdat_q[0], 8'h10);
    chk("I data 1", wdat_q[1], 8'h00);
    chk("I done cycle", done_c, 39);
    chk("I busy low cycle", busy_lo_c, 40);
    chk("I RD_n low cycles", rdlow_cnt, 0);

    // 4: M_S burst, then L burst with a stray start and Control change
    run_burst(2'b11, -1, -1, 20);
    chk("MS CS_n low cycles", cslow_cnt, 0);
    chk("MS done cycle", done_c, 1);
    chk("MS busy low cycle", busy_lo_c, 2);
    run_burst(2'b01, 50, -1, 400);
    chk("L2 rd count", rdi_q.size(), 9);
    chk("L2 last rd_idx", rdi_q[8], 8);
    chk("L2 done cycle", done_c, 172 + 19 * CMD);
    chk("L2 done pulses", done_pulses, 1);
    chk("L2 wdata count", wdat_q.size(), CMD);

    // 5: reset during the data phase of read idx 4
    run_burst(2'b01, -1, 90 + 19 * CMD, 400);
    chk("R RD_n low before reset", rd_n_at_rst, 0);
    chk("R reads before reset", rdi_q.size(), 4);
    #1;
    chk("R CS_n", CS_n, 1);
    chk("R RD_n", RD_n, 1);
    chk("R WR_n", WR_n, 1);
    chk("R AD_n", AD_n, 1);
    chk("R ad_oe", ad_oe, 0);
    chk("R busy", busy, 0);
    chk("R rd_valid", rd_valid, 0);
    chk("R rd_data", rd_data, 0);
    chk("R rd_idx", rd_idx, 0);
    chk("R wr_idx", wr_idx, 0);
    rv = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge reloj);
      if (c == 3) resetM = 1'b1;
      if (rd_valid || busy) rv++;
    end
    chk("R no activity after reset", rv, 0);
    run_burst(2'b01, -1, -1, 400);
    chk("R restart rd count", rdi_q.size(), 9);
    chk("R restart first idx", rdi_q[0], 0);
    chk("R restart first data", rdd_q[0], 8'h30);
    chk("R restart first reg addr", addr_q[CMD], 8'h21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Executes the physical register accesses on the RTC chip's multiplexed address/data bus for the mode chosen by the general control machine.
- Modes are I (init), L (read), E (write) and M_S (status).
- On a start strobe it latches the 2-bit Control mode and runs that mode's fixed burst of address-phase/data-phase accesses.
- Read data goes to the time/date registers; write data is pulled by index from the programming path.
- Sits between the general control machine (Control, sync) and the RTC chip pins.

Parameters:
T_PH, 8, cycles per address phase and per data phase (min 2)
T_GAP, 2, idle cycles after each data phase (min 1)
N_REG, 9, registers per L/E burst (fixed address table, max 9)

Ports:
reloj  input  1  system clock, all logic on rising edge
resetM  input  1  asynchronous, active-low reset
Control  input  2  mode: 00=I, 01=L, 10=E, 11=M_S; sampled only on start
start  input  1  one-cycle strobe that begins a burst
wr_data  input  8  write byte for register wr_idx
wr_idx  output  4  index of the register being written
rd_data  output  8  last byte read
rd_idx  output  4  index of rd_data
rd_valid  output  1  one-cycle strobe, rd_data/rd_idx valid
busy  output  1  burst in progress
done  output  1  one-cycle strobe at end of burst
CS_n  output  1  chip select, active low
RD_n  output  1  read strobe, active low
WR_n  output  1  write strobe, active low
AD_n  output  1  0 = address phase, 1 = data phase
ad_out  output  8  bus drive value
ad_oe  output  1  bus output enable
ad_in  input  8  bus sample value

Behaviour:
- Reset (resetM=0, takes effect immediately, even mid-burst):
  - CS_n=RD_n=WR_n=AD_n=1.
  - ad_oe=0, ad_out=0, busy=0, done=0, rd_valid=0.
  - rd_data=0, rd_idx=0, wr_idx=0.
  - FSM=IDLE, counters=0. The aborted burst is not resumed.
- FSM states: IDLE, ADDR, GAP1, DATA, GAP2, DONE.
- IDLE:
  - start=1 at edge k latches Control into mode and clears idx.
  - M_S goes straight to DONE; every other mode goes to ADDR.
  - busy=1 from k+1.
  - start while busy is ignored. Control changes during a burst are ignored.
- Address table (idx 0..8): 0x21..0x26 (sec, min, hour, day, month, year), then 0x41..0x43 (timer h/m/s).
- Burst content per mode:
  - I: 2 writes, both to 0x02: data 0x10, then data 0x00.
  - L: N_REG reads over the table.
  - E: N_REG writes over the table.
  - M_S: no bus cycles; done at k+1, busy=0 at k+2.
- ADDR (T_PH cycles): CS_n=0, WR_n=0, AD_n=0, ad_oe=1, ad_out=address.
  - In write modes, wr_data is registered on the first ADDR cycle; wr_idx=idx throughout the access.
- GAP1 (1 cycle): all strobes high, CS_n=1, ad_oe holds its value from ADDR.
- DATA (T_PH cycles): CS_n=0, AD_n=1.
  - Write: WR_n=0, ad_oe=1, ad_out=registered byte.
  - Read: RD_n=0, ad_oe=0. ad_in is captured on the last DATA cycle; rd_valid pulses the next cycle with rd_idx=idx.
- GAP2 (T_GAP cycles): all high, ad_oe=0. Then idx+1 → ADDR, or → DONE after the last access.
- DONE (1 cycle): done=1, busy=1. Next cycle IDLE with busy=0.
- Access length = 2*T_PH+1+T_GAP cycles (19 with defaults).
- RD_n and WR_n are never low together. CS_n is high whenever both strobes are high.
- Phase counters are 5 bits and saturate-free; T_PH and T_GAP must be below 32.

Optional Feature:
RTC_XFER_CMD_EN
- Defined: each L burst is prefixed with a command access, and each E burst is suffixed with one.
  - L prefix: address 0xF0, write of data 0xF0 (copy RTC into RAM).
  - E suffix: address 0xF1, write of data 0xF1 (copy RAM into RTC).
  - Each command access is a full-length write. It does not change wr_idx and produces no rd_valid.
- Undefined: no command accesses; bursts are exactly as listed above.

Test Plan:
1. Reset, then Control=01 and one start pulse, with ad_in driven to 0x30+idx during each DATA phase → 9 rd_valid pulses with rd_idx 0..8 and rd_data 0x30..0x38; done at cycle 172 after start; busy low at 173; addresses 0x21..0x26, 0x41..0x43 in order.
2. Control=10, wr_data=0x50+wr_idx → 9 writes with ad_out in DATA = 0x50..0x58; WR_n low only in ADDR/DATA; RD_n held 1; no rd_valid.
3. Control=00 → two accesses to 0x02 with data 0x10 then 0x00; done at cycle 39 after start.
4. Control=11 → no CS_n activity; done at k+1. A second start during an L burst is ignored (still exactly 9 reads). Control toggled mid-burst has no effect.
5. resetM low during DATA of read idx 4 → all strobes high and ad_oe=0 immediately; no rd_valid; a later start restarts at idx 0.
6. With RTC_XFER_CMD_EN: an L burst begins with address 0xF0 and done moves to cycle 191; an E burst ends with an 0xF1 access.
